// File: rtl/bep_pkg.sv
// Shared types and constants for the BEP frame sequencer and the serial_decode
// field layout (32+16+16+32+32+16+16+8+8+8+8 bits per frame).
package bep_pkg;

  typedef logic [1:0] bep_state_t;

  localparam bep_state_t ST_IDLE  = 2'd0;
  localparam bep_state_t ST_ARMED = 2'd1;
  localparam bep_state_t ST_SHIFT = 2'd2;
  localparam bep_state_t ST_CHECK = 2'd3;

  localparam int unsigned BEP_FRAME_BITS = 192;
  localparam int unsigned BEP_IDLE_BITS  = 16;
  localparam logic [31:0] BEP_PREAMBLE   = 32'hAAAA_AAAA;
  localparam logic [23:0] BEP_TAIL       = 24'h00_00_00;

  localparam int unsigned BEP_PREAMBLE_W = 32;
  localparam int unsigned BEP_WORD_W     = 16;
  localparam int unsigned BEP_DWORD_W    = 32;
  localparam int unsigned BEP_BYTE_W     = 8;
  localparam int unsigned BEP_TAIL_W     = 3 * BEP_BYTE_W;
  localparam int unsigned BEP_COUNT_W    = 8;

endpackage

// File: rtl/bep_frame_sequencer_if.sv
// Line, decoder-field and status signals of the BEP frame sequencer.
// master = host/line side driving the inputs, slave = the sequencer.
interface bep_frame_sequencer_if;
  import bep_pkg::*;

  logic                      enable;
  logic                      serial_data;
  logic [BEP_PREAMBLE_W-1:0] preamble_in;
  logic [BEP_TAIL_W-1:0]     tail_in;
  logic                      shift_en;
  logic                      decoder_clear;
  logic                      frame_done;
  logic                      frame_error;
  logic                      busy;
  logic [BEP_COUNT_W-1:0]    frame_count;
  logic [BEP_COUNT_W-1:0]    error_count;

  modport master (
    output enable, serial_data, preamble_in, tail_in,
    input  shift_en, decoder_clear, frame_done, frame_error, busy,
           frame_count, error_count
  );

  modport slave (
    input  enable, serial_data, preamble_in, tail_in,
    output shift_en, decoder_clear, frame_done, frame_error, busy,
           frame_count, error_count
  );

endinterface

// File: rtl/bep_idle_gap_detector.sv
// Consecutive-ones counter on the serial line; gap_seen marks the cycle that
// completes a run of IDLE_BITS ones. Used for both gap search and truncation.
module bep_idle_gap_detector #(
  parameter int unsigned IDLE_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic bit_in,
  output logic gap_seen
);

  localparam logic [7:0] LAST_ONE = 8'(IDLE_BITS - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    gap_seen = bit_in && (cnt_q == LAST_ONE);
    cnt_d    = cnt_q;
    if (clear || !bit_in) begin
      cnt_d = '0;
    end else if (!gap_seen) begin
      // holds at the terminal value while the line stays high
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bep_frame_sequencer.sv
// BEP frame sequencer: gates decoder shifting for one frame and validates it.
// Build option: define BEP_TAIL_CHECK_EN to also require tail_in == TAIL.
//   state | meaning
//   IDLE  | counting line ones to find an inter-frame gap
//   ARMED | gap seen, waiting for the start bit
//   SHIFT | shifting frame bits into the decoder
//   CHECK | one cycle to validate the captured fields
module bep_frame_sequencer
  import bep_pkg::*;
#(
  parameter int unsigned FRAME_BITS = BEP_FRAME_BITS,
  parameter int unsigned IDLE_BITS  = BEP_IDLE_BITS,
  parameter logic [31:0] PREAMBLE   = BEP_PREAMBLE
`ifdef BEP_TAIL_CHECK_EN
  , parameter logic [23:0] TAIL     = BEP_TAIL
`endif
) (
  input logic                  serial_clock,
  input logic                  reset,
  bep_frame_sequencer_if.slave bus
);

  localparam logic [7:0] LAST_BIT = 8'(FRAME_BITS - 1);

  bep_state_t state_q, state_d;
  logic [7:0] bit_count_q, bit_count_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic [7:0] error_count_q, error_count_d;
  logic       decoder_clear_q, decoder_clear_d;
  logic       gap_seen, gap_clear, fields_ok;
  logic       shift_en, frame_done, frame_error;

`ifdef BEP_TAIL_CHECK_EN
  assign fields_ok = (bus.preamble_in == PREAMBLE) && (bus.tail_in == TAIL);
`else
  assign fields_ok = (bus.preamble_in == PREAMBLE);
`endif

  // The ones counter restarts after every frame and whenever the block is off.
  assign gap_clear = !bus.enable || (state_q == ST_CHECK);

  bep_idle_gap_detector #(.IDLE_BITS(IDLE_BITS)) u_gap (
    .clk      (serial_clock),
    .rst      (reset),
    .clear    (gap_clear),
    .bit_in   (bus.serial_data),
    .gap_seen (gap_seen)
  );

  always_comb begin
    state_d         = state_q;
    bit_count_d     = bit_count_q;
    frame_count_d   = frame_count_q;
    error_count_d   = error_count_q;
    decoder_clear_d = 1'b0;
    shift_en        = 1'b0;
    frame_done      = 1'b0;
    frame_error     = 1'b0;
    if (!bus.enable) begin
      state_d     = ST_IDLE;
      bit_count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gap_seen) begin
            state_d         = ST_ARMED;
            decoder_clear_d = 1'b1;
          end
        end
        ST_ARMED: begin
          if (!bus.serial_data) begin
            shift_en    = 1'b1;
            state_d     = ST_SHIFT;
            bit_count_d = 8'd1;
          end
        end
        ST_SHIFT: begin
          shift_en = 1'b1;
          // a truncation on the final bit wins over entering CHECK
          if (gap_seen) begin
            frame_error     = 1'b1;
            state_d         = ST_ARMED;
            bit_count_d     = '0;
            decoder_clear_d = 1'b1;
          end else if (bit_count_q == LAST_BIT) begin
            state_d     = ST_CHECK;
            bit_count_d = '0;
          end else begin
            bit_count_d = bit_count_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          if (fields_ok) begin
            frame_done    = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
          end else begin
            frame_error = 1'b1;
          end
        end
      endcase
    end
    if (frame_error && (error_count_q != 8'hFF)) error_count_d = error_count_q + 8'd1;
  end

  always_ff @(posedge serial_clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      bit_count_q     <= '0;
      frame_count_q   <= '0;
      error_count_q   <= '0;
      decoder_clear_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_count_q     <= bit_count_d;
      frame_count_q   <= frame_count_d;
      error_count_q   <= error_count_d;
      decoder_clear_q <= decoder_clear_d;
    end
  end

  assign bus.shift_en      = shift_en;
  assign bus.decoder_clear = decoder_clear_q;
  assign bus.frame_done    = frame_done;
  assign bus.frame_error   = frame_error;
  assign bus.busy          = (state_q == ST_SHIFT) || (state_q == ST_CHECK);
  assign bus.frame_count   = frame_count_q;
  assign bus.error_count   = error_count_q;

endmodule
